ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the prefetch queue depth in entries; legal values are powers of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0, SHALL set the first fetch address after reset.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mem_req  out  1  instruction-memory read request, registered.
REQ-006 mem_addr  out  32  word address of the request, registered, bits [1:0] always 0.
REQ-007 mem_ack  in  1  memory has returned data for the current request this cycle.
REQ-008 mem_rdata  in  32  read data, valid only when mem_ack=1.
REQ-009 instr_valid  out  1  queue head holds a valid instruction.
REQ-010 instr  out  32  queue head instruction word.
REQ-011 instr_pc  out  32  address the head instruction was fetched from.
REQ-012 instr_ready  in  1  core consumes the head this cycle.
REQ-013 redirect  in  1  taken branch or PC write; flush and refetch.
REQ-014 redirect_pc  in  32  new fetch address; bits [1:0] SHALL be ignored and treated as 0.

Function
REQ-015 The block SHALL hold a fetch pointer fetch_pc, a DEPTH-entry FIFO of {pc, instr}, an occupancy count 0..DEPTH, and a 3-state FSM: IDLE, REQ, DISCARD.
REQ-016 At most one memory request SHALL be outstanding; mem_req and mem_addr SHALL be held stable while mem_req=1 until the edge on which mem_ack=1 is sampled.
REQ-017 mem_ack SHALL be ignored when mem_req=0.
REQ-018 IDLE: if redirect=0 and count<DEPTH, next state REQ with mem_req=1, mem_addr=fetch_pc; otherwise stay IDLE with mem_req=0.
REQ-019 REQ, mem_ack=1, redirect=0: push {mem_addr, mem_rdata}; fetch_pc += 4 (mod 2^32); if count after this cycle's push/pop < DEPTH, stay REQ with mem_addr=new fetch_pc (back-to-back, one fetch per cycle), else go IDLE with mem_req=0.
REQ-020 REQ, mem_ack=0, redirect=1: go DISCARD; mem_req and mem_addr held; fetch_pc=redirect_pc.
REQ-021 REQ, mem_ack=1, redirect=1: returned data SHALL be dropped; fetch_pc=redirect_pc; go IDLE.
REQ-022 DISCARD: mem_req held high; on mem_ack=1, data dropped, go IDLE; redirect in DISCARD (with or without ack) SHALL overwrite fetch_pc and never produce a push.
REQ-023 Redirect SHALL clear the FIFO (count=0) on the same edge; a simultaneous pop or push SHALL be ignored; instr_valid SHALL be 0 the cycle after redirect.
REQ-024 The FIFO SHALL be first-word-fall-through: instr_valid=(count!=0), instr/instr_pc show the oldest entry combinationally from registers.
REQ-025 Pop SHALL occur when instr_valid=1, instr_ready=1, and redirect=0; instr_ready with instr_valid=0 SHALL have no effect.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-027 Requests SHALL only be issued with count<DEPTH, so a push never finds the FIFO full; count SHALL never exceed DEPTH or underflow.
REQ-028 Latency: mem_ack sampled on edge N -> instruction visible at instr with instr_valid=1 in cycle N+1.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 While reset=1: mem_req=0, mem_addr=0, count=0, instr_valid=0, FSM=IDLE, fetch_pc=RESET_PC; instr and instr_pc are don't-care.
REQ-031 Reset asserted mid-request SHALL abandon the request immediately; a later mem_ack with mem_req=0 SHALL be ignored.
REQ-032 The first edge after reset deasserts SHALL drive mem_req=1, mem_addr=RESET_PC.

Verification
REQ-033 Zero-wait memory (ack whenever req), instr_ready=1 -> instr_pc sequence 0,4,8,... one per cycle, instructions match memory.
REQ-034 instr_ready=0, ack always -> exactly 4 pushes (pc 0..12), mem_req drops to 0, instr_valid stays 1; raise instr_ready -> fetching resumes at pc 16.
REQ-035 3-cycle ack latency, redirect to 0x100 one cycle after req at 0x8 -> mem_addr held 0x8 until ack, that data dropped, next request at 0x100, first delivered instr_pc=0x100.
REQ-036 Redirect to 0x40 coincident with mem_ack and instr_ready with 3 entries queued -> FIFO empty next cycle, no push, next request at 0x40.
REQ-037 Assert reset while mem_req=1 at address 0x20 -> mem_req=0 and instr_valid=0 immediately; after release, first request at RESET_PC.
REQ-038 redirect_pc=32'hFFFF_FFFC, ack always -> instr_pc FFFF_FFFC then 0000_0000 (wrap).

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: one outstanding memory read at a time feeding a
// first-word-fall-through FIFO of {pc, instr}, flushed and refetched on redirect.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];

    logic          push;
    logic          pop;
    logic [CW-1:0] count_after;
    logic [31:0]   redirect_target;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign instr_valid = (count_q != '0);
    assign instr       = fifo_instr_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    // Only a live (non-discarded) request may push; a redirect drops its data.
    assign push        = (state_q == REQ) && mem_ack && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;
    assign count_after = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                end else if (count_q < FULL) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (redirect) begin
                        fetch_pc_d = redirect_target;
                        state_d    = IDLE;
                        mem_req_d  = 1'b0;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (count_after < FULL) begin
                            mem_addr_d = fetch_pc_q + 32'd4;
                        end else begin
                            state_d   = IDLE;
                            mem_req_d = 1'b0;
                        end
                    end
                end else if (redirect) begin
                    // Request stays on the bus until acked, but its data is stale.
                    state_d    = DISCARD;
                    fetch_pc_d = redirect_target;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                end
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_d  = count_after;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Entry storage carries no reset: contents are qualified by count_q.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PW'(gi))) begin
                fifo_pc_q[gi]    <= mem_addr_q;
                fifo_instr_q[gi] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and randomized stimulus for ifetch_queue, checked against a
// transaction-level model: a queue of fetched words plus the expected fetch pointer.
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: words in delivery order, next address to be fetched,
    // and whether the request currently on the bus was overtaken by a redirect.
    logic [31:0] q_pc  [$];
    logic [31:0] q_ins [$];
    logic [31:0] m_fetch;
    bit          m_stale;
    int          n_push;

    // Memory responder state.
    bit busy;
    int wait_cnt;
    int lat_mode;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_ins.delete();
        m_fetch = RESET_PC;
        m_stale = 1'b0;
        busy    = 1'b0;
        n_push  = 0;
    endtask

    task automatic apply_reset(input int cycles);
        reset     = 1'b1;
        redirect  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_hold_req", 32'(mem_req), 32'd0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic tick();
        logic        s_req, s_ack, s_redir, s_ready;
        logic [31:0] s_addr, s_rd, s_rpc;
        int          size_pre;
        bit          pop, push, exp_req;
        logic [31:0] exp_addr;

        if (mem_req === 1'b1) begin
            if (!busy) begin
                busy     = 1'b1;
                wait_cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            if (wait_cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = memf(mem_addr);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                wait_cnt--;
            end
        end else begin
            // Acks without a request must be ignored by the design.
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end

        s_req   = mem_req;
        s_addr  = mem_addr;
        s_ack   = mem_ack;
        s_rd    = mem_rdata;
        s_redir = redirect;
        s_rpc   = redirect_pc;
        s_ready = instr_ready;

        @(posedge clk);
        #1;

        size_pre = q_pc.size();
        pop  = (size_pre != 0) && s_ready && !s_redir;
        push = s_req && s_ack && !s_redir && !m_stale;
        if (push) begin
            check("push_addr", s_addr, m_fetch);
            check("push_room", 32'(size_pre < DEPTH), 32'd1);
        end

        if (!s_req)
            exp_req = !s_redir && (size_pre < DEPTH);
        else if (!s_ack)
            exp_req = 1'b1;
        else
            exp_req = !s_redir && !m_stale && (size_pre - int'(pop) + 1 < DEPTH);

        if (s_redir) begin
            q_pc.delete();
            q_ins.delete();
            m_fetch = s_rpc & 32'hFFFF_FFFC;
        end else begin
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (push) begin
                q_pc.push_back(s_addr);
                q_ins.push_back(s_rd);
                m_fetch = m_fetch + 32'd4;
                n_push++;
            end
        end
        if (s_req && s_redir && !s_ack) m_stale = 1'b1;
        if (s_req && s_ack) begin
            m_stale = 1'b0;
            busy    = 1'b0;
        end

        exp_addr = (s_req && !s_ack) ? s_addr : m_fetch;
        check("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) check("mem_addr", mem_addr, exp_addr);
        check("instr_valid", 32'(instr_valid), 32'(q_pc.size() != 0));
        if (q_pc.size() != 0) begin
            check("instr_pc", instr_pc, q_pc[0]);
            check("instr", instr, q_ins[0]);
        end
    endtask

    initial begin
        bit found;

        reset       = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        lat_mode    = 0;
        model_reset();
        #1;

        // Zero-wait memory, consumer always ready: one instruction per cycle.
        apply_reset(3);
        lat_mode    = 0;
        instr_ready = 1'b1;
        tick();
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", mem_addr, RESET_PC);
        for (int k = 2; k < 22; k++) begin
            tick();
            check("stream_valid", 32'(instr_valid), 32'd1);
            check("stream_pc", instr_pc, RESET_PC + 32'(4 * (k - 2)));
        end

        // Stalled consumer: the queue fills to DEPTH and fetching stops.
        apply_reset(2);
        instr_ready = 1'b0;
        repeat (10) tick();
        check("full_pushes", 32'(n_push), 32'd4);
        check("full_req", 32'(mem_req), 32'd0);
        check("full_valid", 32'(instr_valid), 32'd1);
        check("full_head", instr_pc, 32'h0);
        instr_ready = 1'b1;
        tick();
        tick();
        check("resume_req", 32'(mem_req), 32'd1);
        check("resume_addr", mem_addr, 32'h10);

        // Slow memory with a redirect while the request at 0x8 is pending.
        apply_reset(2);
        lat_mode    = 3;
        instr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (mem_req && mem_addr == 32'h8) found = 1'b1;
        end
        check("reach_req_8", 32'(found), 32'd1);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect    = 1'b0;
        check("redir_flush", 32'(instr_valid), 32'd0);
        check("redir_hold_addr", mem_addr, 32'h8);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (mem_req && mem_addr != 32'h8) found = 1'b1;
        end
        check("redir_new_req", 32'(found), 32'd1);
        check("redir_new_addr", mem_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (instr_valid) found = 1'b1;
        end
        check("redir_deliver", 32'(found), 32'd1);
        check("redir_first_pc", instr_pc, 32'h100);

        // Redirect coincident with ack and pop, three entries queued.
        apply_reset(2);
        lat_mode    = 0;
        instr_ready = 1'b0;
        for (int i = 0; i < 20 && n_push < 3; i++) tick();
        check("three_queued", 32'(n_push), 32'd3);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        check("coinc_valid", 32'(instr_valid), 32'd0);
        check("coinc_no_push", 32'(n_push), 32'd3);
        check("coinc_req", 32'(mem_req), 32'd0);
        tick();
        check("coinc_next_req", 32'(mem_req), 32'd1);
        check("coinc_next_addr", mem_addr, 32'h40);

        // Reset in the middle of a request at 0x20.
        apply_reset(2);
        lat_mode    = 3;
        instr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (mem_req && mem_addr == 32'h20) found = 1'b1;
        end
        check("reach_req_20", 32'(found), 32'd1);
        apply_reset(2);
        tick();
        check("post_rst_req", 32'(mem_req), 32'd1);
        check("post_rst_addr", mem_addr, RESET_PC);

        // Fetch pointer wraps past the top of the address space.
        lat_mode    = 0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (instr_valid) found = 1'b1;
        end
        check("wrap_deliver", 32'(found), 32'd1);
        check("wrap_pc_top", instr_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_valid", 32'(instr_valid), 32'd1);
        check("wrap_pc_zero", instr_pc, 32'h0);

        // Random traffic: variable latency, stalls, redirects with unaligned targets.
        lat_mode = -1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) apply_reset(1);
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            tick();
        end
        redirect = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
